axi_scan_wrapper: RTL and testbench

Register-mapped test wrapper between the 32-bit AXI-side register interface and one DUT plus up to `P_SC_NBR` DFT scan chains. It generalises the existing prewrapper in four ways: parametrised chain count and FIFO depth, a per-chain enable mask, a timeout watchdog, and a capture FIFO that buffers strobed scan words. Software loads the input vector, issues an opcode, and polls status. It then reads the latched output vector and drains scan data from the FIFO.

---
 rtl/axi_scan_wrapper_pkg.sv | 36 +++
 rtl/scan_capture_fifo.sv | 86 ++++++++
 rtl/axi_scan_wrapper.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi_scan_wrapper.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_scan_wrapper_pkg.sv
// Shared types and constants for the AXI scan wrapper: FSM states, opcodes,
// register word addresses and STATUS field positions.
package axi_scan_wrapper_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_DUT_REQ  = 4'd1,
      ST_DUT_WAIT = 4'd2,
      ST_DUT_ACK  = 4'd3,
      ST_DFT_REQ  = 4'd4,
      ST_DFT_WAIT = 4'd5,
      ST_DFT_ACK  = 4'd6,
      ST_RST_HOLD = 4'd7
   } state_e;

   localparam logic [31:0] OP_NOP       = 32'd0;
   localparam logic [31:0] OP_DUT_RUN   = 32'd1;
   localparam logic [31:0] OP_DFT_SCAN  = 32'd2;
   localparam logic [31:0] OP_DUT_RESET = 32'd3;
   localparam logic [31:0] OP_CLEAR     = 32'd4;

   localparam logic [31:0] ADDR_STATUS   = 32'h00;
   localparam logic [31:0] ADDR_OPCODE   = 32'h01;
   localparam logic [31:0] ADDR_CONFIG   = 32'h02;
   localparam logic [31:0] ADDR_TIMEOUT  = 32'h03;
   localparam logic [31:0] ADDR_FIFO     = 32'h04;
   localparam logic [31:0] ADDR_IN_BASE  = 32'h10;
   localparam logic [31:0] ADDR_OUT_BASE = 32'h40;

   localparam int STS_BUSY    = 4;
   localparam int STS_TIMEOUT = 5;
   localparam int STS_OVF     = 6;
   localparam int STS_BUSYERR = 7;
   localparam int STS_CNT_LSB = 8;

endpackage

// File: rtl/scan_capture_fifo.sv
// Per-chain one-word pending registers feeding a synchronous capture FIFO;
// the lowest-index pending word is pushed each cycle the FIFO has room.
module scan_capture_fifo
   import axi_scan_wrapper_pkg::*;
#(
   parameter int P_SC_NBR     = 16,
   parameter int P_FIFO_DEPTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear_i,
   input  logic [P_SC_NBR-1:0]     mask_i,
   input  logic [P_SC_NBR-1:0]     strobe_i,
   input  logic [32*P_SC_NBR-1:0]  data_i,
   input  logic                    pop_i,
   output logic [31:0]             head_o,
   output logic                    empty_o,
   output logic [7:0]              count_o,
   output logic                    ovf_o
);

   localparam int AW = $clog2(P_FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [P_SC_NBR-1:0] pend_vld_q, pend_vld_d;
   logic [31:0]         pend_data_q [P_SC_NBR];
   logic [31:0]         mem_q [P_FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]       cnt_q;
   logic [P_SC_NBR-1:0] sel_oh, stb, free, accept, pushed;
   logic [31:0]         sel_data;
   logic                full, push, pop;

   always_comb begin
      sel_oh   = '0;
      sel_data = '0;
      for (int i = P_SC_NBR - 1; i >= 0; i--) begin
         if (pend_vld_q[i]) begin
            sel_oh    = '0;
            sel_oh[i] = 1'b1;
            sel_data  = pend_data_q[i];
         end
      end
   end

   assign full   = (cnt_q == CW'(P_FIFO_DEPTH));
   assign push   = (|pend_vld_q) && !full && !clear_i;
   assign pop    = pop_i && (cnt_q != '0) && !clear_i;
   assign pushed = push ? sel_oh : '0;
   // A slot emptied by this cycle's push may be refilled in the same cycle.
   assign stb    = strobe_i & mask_i & {P_SC_NBR{~clear_i}};
   assign free   = ~pend_vld_q | pushed;
   assign accept = stb & free;
   assign ovf_o  = |(stb & ~free);
   assign pend_vld_d = (pend_vld_q & ~pushed) | accept;

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         pend_vld_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         pend_vld_q <= pend_vld_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < P_SC_NBR; i++) begin
         if (accept[i]) pend_data_q[i] <= data_i[32*i +: 32];
      end
      if (push) mem_q[wr_ptr_q] <= sel_data;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (cnt_q == '0);
   assign count_o = 8'(cnt_q);

endmodule

// File: rtl/axi_scan_wrapper.sv
// Register-mapped test wrapper: register file, operation FSM with watchdog,
// and scan capture into a FIFO drained through FIFO_DATA reads.
module axi_scan_wrapper
   import axi_scan_wrapper_pkg::*;
#(
   parameter int P_SC_NBR     = 16,
   parameter int P_DUT_IN_W   = 256,
   parameter int P_DUT_OUT_W  = 256,
   parameter int P_FIFO_DEPTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    axi_wr_en,
   input  logic [31:0]             axi_wr_addr,
   input  logic [31:0]             axi_wr_msg,
   input  logic                    axi_rd_en,
   input  logic [31:0]             axi_rd_addr,
   output logic [31:0]             axi_rd_msg,
   output logic [P_DUT_IN_W-1:0]   dut_input_vec,
   input  logic [P_DUT_OUT_W-1:0]  dut_output_vec,
   output logic                    dut_val_op,
   input  logic                    dut_op_ack,
   input  logic                    dut_op_commit,
   output logic                    dut_commit_ack,
   output logic                    dut_sen,
   output logic                    dut_rst,
   input  logic [32*P_SC_NBR-1:0]  dft_output_data,
   output logic [P_SC_NBR-1:0]     dft_val_op,
   input  logic [P_SC_NBR-1:0]     dft_op_ack,
   input  logic [P_SC_NBR-1:0]     dft_op_commit,
   input  logic [P_SC_NBR-1:0]     dft_output_strobe,
   output logic [P_SC_NBR-1:0]     dft_commit_ack
);

   localparam int NIN  = P_DUT_IN_W / 32;
   localparam int NOUT = P_DUT_OUT_W / 32;

   state_e                 state_q;
   logic [P_DUT_IN_W-1:0]  in_vec_q;
   logic [P_DUT_OUT_W-1:0] out_vec_q;
   logic [23:0]            cfg_q;
   logic [15:0]            tmo_q, wd_cnt_q;
   logic [7:0]             rst_cnt_q;
   logic [31:0]            rd_msg_q, rd_data, status;
   logic                   timeout_q, ovf_q, busyerr_q;
   logic                   dut_val_op_q, dut_commit_ack_q, dut_sen_q, dut_rst_q;
   logic [P_SC_NBR-1:0]    dft_val_op_q, dft_commit_ack_q, mask_q, done_q, done_d;
   logic [P_SC_NBR-1:0]    cfg_mask, dft_req_left;
   logic                   busy, op_wr, clear, wd_fire, fifo_pop;
   logic [31:0]            fifo_head;
   logic                   fifo_empty, fifo_ovf;
   logic [7:0]             fifo_cnt;

   assign busy     = (state_q != ST_IDLE);
   assign op_wr    = axi_wr_en && (axi_wr_addr == ADDR_OPCODE);
   assign clear    = op_wr && !busy && (axi_wr_msg == OP_CLEAR);
   assign fifo_pop = axi_rd_en && (axi_rd_addr == ADDR_FIFO);
   assign cfg_mask = cfg_q[P_SC_NBR-1:0];
   assign done_d   = done_q | (dft_op_commit & mask_q);
   assign dft_req_left = dft_val_op_q & ~dft_op_ack;
   assign wd_fire  = busy && (state_q != ST_RST_HOLD) && (tmo_q != '0) &&
                     ((wd_cnt_q + 16'd1) == tmo_q);

   scan_capture_fifo #(
      .P_SC_NBR     (P_SC_NBR),
      .P_FIFO_DEPTH (P_FIFO_DEPTH)
   ) u_capture (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (clear),
      .mask_i   (cfg_mask),
      .strobe_i (dft_output_strobe),
      .data_i   (dft_output_data),
      .pop_i    (fifo_pop),
      .head_o   (fifo_head),
      .empty_o  (fifo_empty),
      .count_o  (fifo_cnt),
      .ovf_o    (fifo_ovf)
   );

   always_comb begin
      status                     = '0;
      status[3:0]                = state_q;
      status[STS_BUSY]           = busy;
      status[STS_TIMEOUT]        = timeout_q;
      status[STS_OVF]            = ovf_q;
      status[STS_BUSYERR]        = busyerr_q;
      status[STS_CNT_LSB +: 8]   = fifo_cnt;
   end

   always_comb begin
      rd_data = '0;
      if (axi_rd_addr == ADDR_STATUS)       rd_data = status;
      else if (axi_rd_addr == ADDR_CONFIG)  rd_data = {8'd0, cfg_q};
      else if (axi_rd_addr == ADDR_TIMEOUT) rd_data = {16'd0, tmo_q};
      else if (axi_rd_addr == ADDR_FIFO)    rd_data = fifo_empty ? 32'd0 : fifo_head;
      for (int k = 0; k < NIN; k++) begin
         if (axi_rd_addr == ADDR_IN_BASE + 32'(k)) rd_data = in_vec_q[32*k +: 32];
      end
      for (int k = 0; k < NOUT; k++) begin
         if (axi_rd_addr == ADDR_OUT_BASE + 32'(k)) rd_data = out_vec_q[32*k +: 32];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_q    <= '0;
         tmo_q    <= '0;
         in_vec_q <= '0;
         rd_msg_q <= '0;
      end else begin
         if (axi_wr_en) begin
            if (axi_wr_addr == ADDR_CONFIG)  cfg_q <= axi_wr_msg[23:0];
            if (axi_wr_addr == ADDR_TIMEOUT) tmo_q <= axi_wr_msg[15:0];
            for (int k = 0; k < NIN; k++) begin
               if (axi_wr_addr == ADDR_IN_BASE + 32'(k)) in_vec_q[32*k +: 32] <= axi_wr_msg;
            end
         end
         if (axi_rd_en) rd_msg_q <= rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         out_vec_q        <= '0;
         timeout_q        <= 1'b0;
         ovf_q            <= 1'b0;
         busyerr_q        <= 1'b0;
         dut_val_op_q     <= 1'b0;
         dut_commit_ack_q <= 1'b0;
         dut_sen_q        <= 1'b0;
         dut_rst_q        <= 1'b0;
         dft_val_op_q     <= '0;
         dft_commit_ack_q <= '0;
         mask_q           <= '0;
         done_q           <= '0;
         rst_cnt_q        <= '0;
         wd_cnt_q         <= '0;
      end else begin
         if (clear) begin
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
            busyerr_q <= 1'b0;
         end else begin
            if (fifo_ovf)      ovf_q     <= 1'b1;
            if (op_wr && busy) busyerr_q <= 1'b1;
         end
         if (busy && state_q != ST_RST_HOLD) wd_cnt_q <= wd_cnt_q + 16'd1;

         // Watchdog abort drops every handshake and skips the commit ack.
         if (wd_fire) begin
            timeout_q        <= 1'b1;
            state_q          <= ST_IDLE;
            dut_val_op_q     <= 1'b0;
            dut_commit_ack_q <= 1'b0;
            dut_sen_q        <= 1'b0;
            dft_val_op_q     <= '0;
            dft_commit_ack_q <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  wd_cnt_q <= '0;
                  done_q   <= '0;
                  if (op_wr) begin
                     case (axi_wr_msg)
                        OP_DUT_RUN: begin
                           state_q      <= ST_DUT_REQ;
                           dut_val_op_q <= 1'b1;
                        end
                        OP_DFT_SCAN: begin
                           if (cfg_mask != '0) begin
                              state_q      <= ST_DFT_REQ;
                              mask_q       <= cfg_mask;
                              dft_val_op_q <= cfg_mask;
                              dut_sen_q    <= 1'b1;
                           end
                        end
                        OP_DUT_RESET: begin
                           state_q   <= ST_RST_HOLD;
                           dut_rst_q <= 1'b1;
                           rst_cnt_q <= cfg_q[23:16];
                        end
                        default: ;
                     endcase
                  end
               end
               ST_DUT_REQ: begin
                  if (dut_op_ack) begin
                     dut_val_op_q <= 1'b0;
                     if (dut_op_commit) begin
                        out_vec_q        <= dut_output_vec;
                        dut_commit_ack_q <= 1'b1;
                        state_q          <= ST_DUT_ACK;
                     end else begin
                        state_q <= ST_DUT_WAIT;
                     end
                  end
               end
               ST_DUT_WAIT: begin
                  if (dut_op_commit) begin
                     out_vec_q        <= dut_output_vec;
                     dut_commit_ack_q <= 1'b1;
                     state_q          <= ST_DUT_ACK;
                  end
               end
               ST_DUT_ACK: begin
                  dut_commit_ack_q <= 1'b0;
                  state_q          <= ST_IDLE;
               end
               ST_DFT_REQ: begin
                  dft_val_op_q <= dft_req_left;
                  done_q       <= done_d;
                  if (dft_req_left == '0) state_q <= ST_DFT_WAIT;
               end
               ST_DFT_WAIT: begin
                  done_q <= done_d;
                  if (done_d == mask_q) begin
                     dft_commit_ack_q <= mask_q;
                     state_q          <= ST_DFT_ACK;
                  end
               end
               ST_DFT_ACK: begin
                  dft_commit_ack_q <= '0;
                  dut_sen_q        <= 1'b0;
                  state_q          <= ST_IDLE;
               end
               ST_RST_HOLD: begin
                  if (rst_cnt_q == '0) begin
                     dut_rst_q <= 1'b0;
                     state_q   <= ST_IDLE;
                  end else begin
                     rst_cnt_q <= rst_cnt_q - 8'd1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign axi_rd_msg     = rd_msg_q;
   assign dut_input_vec  = in_vec_q;
   assign dut_val_op     = dut_val_op_q;
   assign dut_commit_ack = dut_commit_ack_q;
   assign dut_sen        = dut_sen_q;
   assign dut_rst        = dut_rst_q;
   assign dft_val_op     = dft_val_op_q;
   assign dft_commit_ack = dft_commit_ack_q;

endmodule

// File: tb/tb_axi_scan_wrapper.sv
// Directed bench for axi_scan_wrapper: register reads are checked by a
// scoreboard monitor, handshake outputs by direct checks at the falling edge.
module tb_axi_scan_wrapper;

   localparam int NSC = 16;
   localparam int IW  = 256;
   localparam int OW  = 256;
   localparam int FD  = 32;

   localparam logic [31:0] A_STATUS  = 32'h00;
   localparam logic [31:0] A_OPCODE  = 32'h01;
   localparam logic [31:0] A_CONFIG  = 32'h02;
   localparam logic [31:0] A_TIMEOUT = 32'h03;
   localparam logic [31:0] A_FIFO    = 32'h04;

   logic            clk = 1'b0;
   logic            reset;
   logic            axi_wr_en, axi_rd_en;
   logic [31:0]     axi_wr_addr, axi_wr_msg, axi_rd_addr, axi_rd_msg;
   logic [IW-1:0]   dut_input_vec;
   logic [OW-1:0]   dut_output_vec;
   logic            dut_val_op, dut_op_ack, dut_op_commit, dut_commit_ack;
   logic            dut_sen, dut_rst;
   logic [32*NSC-1:0] dft_output_data;
   logic [NSC-1:0]  dft_val_op, dft_op_ack, dft_op_commit, dft_output_strobe, dft_commit_ack;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic rd_vld_q;

   axi_scan_wrapper #(
      .P_SC_NBR(NSC), .P_DUT_IN_W(IW), .P_DUT_OUT_W(OW), .P_FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .reset(reset),
      .axi_wr_en(axi_wr_en), .axi_wr_addr(axi_wr_addr), .axi_wr_msg(axi_wr_msg),
      .axi_rd_en(axi_rd_en), .axi_rd_addr(axi_rd_addr), .axi_rd_msg(axi_rd_msg),
      .dut_input_vec(dut_input_vec), .dut_output_vec(dut_output_vec),
      .dut_val_op(dut_val_op), .dut_op_ack(dut_op_ack),
      .dut_op_commit(dut_op_commit), .dut_commit_ack(dut_commit_ack),
      .dut_sen(dut_sen), .dut_rst(dut_rst),
      .dft_output_data(dft_output_data), .dft_val_op(dft_val_op),
      .dft_op_ack(dft_op_ack), .dft_op_commit(dft_op_commit),
      .dft_output_strobe(dft_output_strobe), .dft_commit_ack(dft_commit_ack)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_vld_q <= axi_rd_en;

   // Read-data monitor: one expectation per read strobe, checked a cycle later.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rd_vld_q === 1'b1) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read: got %h with no expectation queued", axi_rd_msg);
         end else begin
            e = sb_q.pop_front();
            if (axi_rd_msg !== e.val) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h", e.name, axi_rd_msg, e.val);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      axi_wr_en = 1'b1; axi_wr_addr = a; axi_wr_msg = d;
      @(negedge clk);
      axi_wr_en = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
      exp_t e;
      e.name = name;
      e.val  = exp;
      sb_q.push_back(e);
      axi_rd_en = 1'b1; axi_rd_addr = a;
      @(negedge clk);
      axi_rd_en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL sim_timeout: got no finish, expected finish before bound");
      $fatal(1, "simulation bound expired");
   end

   initial begin
      int cnt;
      reset = 1'b1;
      axi_wr_en = 1'b0; axi_wr_addr = '0; axi_wr_msg = '0;
      axi_rd_en = 1'b0; axi_rd_addr = '0;
      dut_output_vec = '0; dut_op_ack = 1'b0; dut_op_commit = 1'b0;
      dft_output_data = '0; dft_op_ack = '0; dft_op_commit = '0; dft_output_strobe = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      chk("rst_val_op", 32'(dut_val_op), 32'd0);
      chk("rst_dft_val_op", 32'(dft_val_op), 32'd0);
      chk("rst_sen_rst", {30'd0, dut_sen, dut_rst}, 32'd0);
      rd(A_STATUS, 32'h0, "rst_status");
      rd(32'h10, 32'h0, "rst_in_word0");
      rd(32'h20, 32'h0, "unmapped_read");

      // DUT_RUN: ack at +3, commit at +6
      wr(32'h10, 32'h1234);
      rd(32'h10, 32'h1234, "in_word0_rb");
      chk("in_vec_word0", dut_input_vec[31:0], 32'h1234);
      dut_output_vec[31:0] = 32'hCAFE;
      wr(A_OPCODE, 32'd1);
      chk("dut_val_op_req", 32'(dut_val_op), 32'd1);
      cnt = 0;
      for (int c = 1; c <= 10; c++) begin
         dut_op_ack    = (c == 3);
         dut_op_commit = (c == 6);
         @(negedge clk);
         if (dut_commit_ack) cnt++;
         if (c == 4) chk("dut_val_op_dropped", 32'(dut_val_op), 32'd0);
      end
      dut_op_ack = 1'b0; dut_op_commit = 1'b0;
      chk("dut_commit_ack_pulses", 32'(cnt), 32'd1);
      rd(32'h40, 32'hCAFE, "out_word0");
      rd(A_STATUS, 32'h0, "status_after_run");

      // DUT_RUN with ack and commit in the same cycle
      dut_output_vec[31:0] = 32'hBEEF;
      wr(A_OPCODE, 32'd1);
      dut_op_ack = 1'b1; dut_op_commit = 1'b1;
      @(negedge clk);
      dut_op_ack = 1'b0; dut_op_commit = 1'b0;
      chk("same_cycle_commit_ack", 32'(dut_commit_ack), 32'd1);
      @(negedge clk);
      rd(32'h40, 32'hBEEF, "out_word0_same_cycle");

      // DFT_SCAN with mask 0x5
      wr(A_CONFIG, 32'h5);
      wr(A_OPCODE, 32'd2);
      chk("dft_val_op_mask", 32'(dft_val_op), 32'h5);
      chk("dut_sen_req", 32'(dut_sen), 32'd1);
      dft_op_ack = 16'h5;
      @(negedge clk);
      dft_op_ack = '0;
      chk("dft_val_op_acked", 32'(dft_val_op), 32'd0);
      rd(A_STATUS, 32'h15, "status_dft_wait");
      dft_output_strobe = 16'h5;
      dft_output_data[31:0]  = 32'hA0;
      dft_output_data[95:64] = 32'hA2;
      @(negedge clk);
      dft_output_strobe = '0;
      dft_op_commit = 16'h5;
      @(negedge clk);
      dft_op_commit = '0;
      chk("dft_commit_ack", 32'(dft_commit_ack), 32'h5);
      chk("dut_sen_ack", 32'(dut_sen), 32'd1);
      @(negedge clk);
      chk("dft_commit_ack_done", 32'(dft_commit_ack), 32'd0);
      chk("dut_sen_idle", 32'(dut_sen), 32'd0);
      rd(A_STATUS, 32'h0200, "status_fifo2");
      rd(A_FIFO, 32'hA0, "fifo_pop0");
      rd(A_FIFO, 32'hA2, "fifo_pop1");
      rd(A_STATUS, 32'h0, "status_fifo_drained");

      // FIFO fill and overflow on chain 0
      wr(A_CONFIG, 32'h1);
      for (int i = 0; i < FD + 2; i++) begin
         dft_output_strobe = 16'h1;
         dft_output_data[31:0] = 32'h100 + 32'(i);
         @(negedge clk);
      end
      dft_output_strobe = '0;
      @(negedge clk);
      rd(A_STATUS, (32'(FD) << 8) | 32'h40, "status_full_ovf");
      for (int i = 0; i <= FD; i++) rd(A_FIFO, 32'h100 + 32'(i), "fifo_word");
      rd(A_FIFO, 32'h0, "fifo_empty_read");
      rd(A_STATUS, 32'h40, "status_ovf_empty");
      wr(A_OPCODE, 32'd4);
      rd(A_STATUS, 32'h0, "status_after_clear");

      // Watchdog
      wr(A_TIMEOUT, 32'd10);
      rd(A_TIMEOUT, 32'd10, "timeout_rb");
      wr(A_OPCODE, 32'd1);
      repeat (9) @(negedge clk);
      chk("wd_still_req", 32'(dut_val_op), 32'd1);
      @(negedge clk);
      chk("wd_val_op_dropped", 32'(dut_val_op), 32'd0);
      rd(A_STATUS, 32'h20, "status_timeout");
      wr(A_OPCODE, 32'd4);
      wr(A_TIMEOUT, 32'd0);

      // DUT_RESET with rst_len=3 and an opcode write while busy
      wr(A_CONFIG, 32'h0003_0000);
      wr(A_OPCODE, 32'd3);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (dut_rst) cnt++;
         axi_wr_en = (i == 1); axi_wr_addr = A_OPCODE; axi_wr_msg = 32'd1;
         @(negedge clk);
      end
      axi_wr_en = 1'b0;
      chk("dut_rst_cycles", 32'(cnt), 32'd4);
      rd(A_STATUS, 32'h80, "status_busy_err");
      wr(A_OPCODE, 32'd4);

      // Reset during DFT_WAIT
      wr(A_CONFIG, 32'h3);
      wr(A_OPCODE, 32'd2);
      chk("dft_val_op_mask3", 32'(dft_val_op), 32'h3);
      dft_op_ack = 16'h3;
      @(negedge clk);
      dft_op_ack = '0;
      rd(A_STATUS, 32'h15, "status_before_reset");
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("reset_rd_msg", axi_rd_msg, 32'h0);
      chk("reset_in_vec", 32'(|dut_input_vec), 32'd0);
      chk("reset_sen", 32'(dut_sen), 32'd0);
      chk("reset_dft_hs", {dft_val_op, dft_commit_ack}, 32'd0);
      chk("reset_dut_hs", {29'd0, dut_val_op, dut_commit_ack, dut_rst}, 32'd0);
      rd(A_STATUS, 32'h0, "status_after_reset");
      rd(A_CONFIG, 32'h0, "config_after_reset");

      repeat (3) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
